// File: rtl/mips_trace_pkg.sv
// Shared record layout for the commit-trace capture path.
// Record = {kind, pc, addr, data}, 98 bits.
package mips_trace_pkg;

    localparam int KIND_W = 2;
    localparam int WORD_W = 32;
    localparam int REC_W  = KIND_W + 3 * WORD_W;

    localparam logic [KIND_W-1:0] KIND_GPR = 2'b01;
    localparam logic [KIND_W-1:0] KIND_DM  = 2'b10;

    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } trace_rec_t;

    function automatic trace_rec_t make_rec(
        input logic [KIND_W-1:0] kind,
        input logic [WORD_W-1:0] pc,
        input logic [WORD_W-1:0] addr,
        input logic [WORD_W-1:0] data
    );
        trace_rec_t r;
        r.kind = kind;
        r.pc   = pc;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Trace record FIFO: two ordered write ports, one read port.
// Full/empty come from the occupancy count, not pointer compare.
module trace_fifo_2w1r
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  trace_rec_t       rec0,
    input  logic             push1,
    input  trace_rec_t       rec1,
    input  logic             pop,
    output trace_rec_t       head,
    output logic [LW-1:0]    level
);

    trace_rec_t mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop_ok;

    assign pop_ok = pop && (level != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + AW'(push0) + AW'(push1);
            rptr  <= rptr + AW'(pop_ok);
            level <= level + LW'(push0) + LW'(push1) - LW'(pop_ok);
        end
    end

    // Port 1 always lands one slot after port 0, keeping GPR-before-DM order.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wptr] <= rec0;
        end
        if (push1) begin
            mem[wptr + AW'(1)] <= rec1;
        end
    end

    assign head = (level != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/commit_trace_buf.sv
// Commit-trace capture: turns GPR/DM writes into buffered trace records.
// Optional COMMIT_TRACE_DROP_R0_EN suppresses GPR writes to r0.
module commit_trace_buf
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             reg_wr,
    input  logic [4:0]       reg_waddr,
    input  logic [31:0]      reg_wdata,
    input  logic             mem_we,
    input  logic [9:0]       mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    trace_rec_t gpr_rec;
    trace_rec_t dm_rec;
    trace_rec_t rec0;
    trace_rec_t rec1;
    trace_rec_t head;

    logic          gpr_ev;
    logic          dm_ev;
    logic          pop;
    logic          push0;
    logic          push1;
    logic [1:0]    n_drop;
    logic [LW:0]   free;
    logic [CNT_W:0] cnt_sum;

`ifdef COMMIT_TRACE_DROP_R0_EN
    assign gpr_ev = reg_wr && (reg_waddr != 5'd0);
`else
    assign gpr_ev = reg_wr;
`endif
    assign dm_ev = mem_we;

    assign gpr_rec = make_rec(KIND_GPR, pc, {27'b0, reg_waddr}, reg_wdata);
    assign dm_rec  = make_rec(KIND_DM, pc, {22'b0, mem_addr}, mem_wdata);

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;

    // A same-cycle pop frees a slot for this cycle's records.
    assign free = (LW + 1)'(DEPTH) - {1'b0, level} + (LW + 1)'(pop);

    always_comb begin
        push0  = 1'b0;
        push1  = 1'b0;
        rec0   = gpr_rec;
        rec1   = dm_rec;
        n_drop = 2'd0;
        if (gpr_ev && dm_ev) begin
            if (free >= (LW + 1)'(2)) begin
                push0 = 1'b1;
                push1 = 1'b1;
            end else if (free == (LW + 1)'(1)) begin
                push0  = 1'b1;
                n_drop = 2'd1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (gpr_ev) begin
            if (free != '0) begin
                push0 = 1'b1;
            end else begin
                n_drop = 2'd1;
            end
        end else if (dm_ev) begin
            rec0 = dm_rec;
            if (free != '0) begin
                push0 = 1'b1;
            end else begin
                n_drop = 2'd1;
            end
        end
    end

    trace_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (push0),
        .rec0  (rec0),
        .push1 (push1),
        .rec1  (rec1),
        .pop   (pop),
        .head  (head),
        .level (level)
    );

    assign out_kind = head.kind;
    assign out_pc   = head.pc;
    assign out_addr = head.addr;
    assign out_data = head.data;

    assign cnt_sum = {1'b0, drop_cnt} + {{(CNT_W - 1){1'b0}}, n_drop};

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            drop_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            if (n_drop != 2'd0) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf: directed scenarios plus random traffic
// checked against a queue-based model of the trace buffer.
module tb_commit_trace_buf;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [1:0]  k;
        logic [31:0] p;
        logic [31:0] a;
        logic [31:0] d;
    } mrec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        reg_wr;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  level;
    logic        overflow;
    logic [CNT_W-1:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    mrec_t mq[$];
    int    m_drop = 0;
    bit    m_ovf = 0;

    commit_trace_buf #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .reg_wr    (reg_wr),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_pc    (out_pc),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reg_wr    = 1'b0;
        mem_we    = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    // One clock edge; the model applies the buffer rules to the held inputs.
    task automatic step();
        bit popped;
        bit g;
        int free;
        mrec_t ev[$];
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            popped = (mq.size() > 0) && out_ready;
`ifdef COMMIT_TRACE_DROP_R0_EN
            g = reg_wr && (reg_waddr != 0);
`else
            g = reg_wr;
`endif
            if (g)
                ev.push_back({2'b01, pc, 27'b0, reg_waddr, reg_wdata});
            if (mem_we)
                ev.push_back({2'b10, pc, 22'b0, mem_addr, mem_wdata});
            free = DEPTH - mq.size() + (popped ? 1 : 0);
            if (popped)
                void'(mq.pop_front());
            foreach (ev[i]) begin
                if (free > 0) begin
                    mq.push_back(ev[i]);
                    free--;
                end else begin
                    m_ovf = 1;
                    if (m_drop < (1 << CNT_W) - 1)
                        m_drop++;
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        idle();
        for (int i = 0; i < 40 && level != 0; i++)
            step();
        tests++;
        if (level !== 5'd0) begin
            fails++;
            $display("FAIL drain: level=%0d required 0", level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        pc = 32'h0;
        idle();
        step();
        step();
        rst = 1'b0;
        tests++;
        if ({out_valid, level, overflow, drop_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_state: v=%b lvl=%0d ovf=%b drop=%0d required 0",
                     out_valid, level, overflow, drop_cnt);
        end
        tests++;
        if ({out_kind, out_pc, out_addr, out_data} !== '0) begin
            fails++;
            $display("FAIL reset_out: kind=%b pc=%h addr=%h data=%h required 0",
                     out_kind, out_pc, out_addr, out_data);
        end
    endtask

    task automatic test_gpr_only();
        out_ready = 1'b0;
        pc        = 32'h0000_3000;
        reg_wr    = 1'b1;
        reg_waddr = 5'd8;
        reg_wdata = 32'h0000_1234;
        step();
        idle();
        tests++;
        if ({out_valid, out_kind, out_addr, out_data, out_pc, level} !==
            {1'b1, 2'b01, 32'h8, 32'h1234, 32'h3000, 5'd1}) begin
            fails++;
            $display("FAIL gpr_only: v=%b k=%b a=%h d=%h pc=%h lvl=%0d required 1 01 8 1234 3000 1",
                     out_valid, out_kind, out_addr, out_data, out_pc, level);
        end
        drain();
    endtask

    task automatic test_dm_stall();
        out_ready = 1'b0;
        pc        = 32'h0000_3004;
        mem_we    = 1'b1;
        mem_addr  = 10'h01C;
        mem_wdata = 32'hDEAD_BEEF;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({out_valid, out_kind, out_addr, out_data, out_pc} !==
                {1'b1, 2'b10, 32'h1C, 32'hDEADBEEF, 32'h3004}) begin
                fails++;
                $display("FAIL dm_stall[%0d]: v=%b k=%b a=%h d=%h pc=%h required 1 10 1c deadbeef 3004",
                         i, out_valid, out_kind, out_addr, out_data, out_pc);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if ({out_valid, level} !== {1'b0, 5'd0}) begin
            fails++;
            $display("FAIL dm_pop: v=%b lvl=%0d required 0 0", out_valid, level);
        end
    endtask

    task automatic test_dual();
        out_ready = 1'b0;
        pc        = 32'h0000_3010;
        reg_wr    = 1'b1;
        reg_waddr = 5'd3;
        reg_wdata = 32'h1111_0003;
        mem_we    = 1'b1;
        mem_addr  = 10'h040;
        mem_wdata = 32'h2222_0040;
        step();
        idle();
        tests++;
        if ({level, out_kind, out_pc, out_addr} !== {5'd2, 2'b01, 32'h3010, 32'h3}) begin
            fails++;
            $display("FAIL dual_first: lvl=%0d k=%b pc=%h a=%h required 2 01 3010 3",
                     level, out_kind, out_pc, out_addr);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if ({level, out_kind, out_pc, out_addr, out_data} !==
            {5'd1, 2'b10, 32'h3010, 32'h40, 32'h22220040}) begin
            fails++;
            $display("FAIL dual_second: lvl=%0d k=%b pc=%h a=%h d=%h required 1 10 3010 40 22220040",
                     level, out_kind, out_pc, out_addr, out_data);
        end
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pc        = 32'h4000 + 32'(i * 4);
            reg_wr    = 1'b1;
            reg_waddr = 5'(i + 1);
            reg_wdata = 32'(i);
            step();
        end
        idle();
        tests++;
        if ({level, overflow} !== {5'd16, 1'b0}) begin
            fails++;
            $display("FAIL fill: lvl=%0d ovf=%b required 16 0", level, overflow);
        end
        reg_wr = 1'b1;
        mem_we = 1'b1;
        step();
        tests++;
        if ({level, overflow, drop_cnt} !== {5'd16, 1'b1, 16'd2}) begin
            fails++;
            $display("FAIL dual_drop: lvl=%0d ovf=%b drop=%0d required 16 1 2",
                     level, overflow, drop_cnt);
        end
        out_ready = 1'b1;
        step();
        idle();
        out_ready = 1'b0;
        tests++;
        if ({level, drop_cnt, out_pc} !== {5'd16, 16'd3, 32'h4004}) begin
            fails++;
            $display("FAIL half_drop: lvl=%0d drop=%0d pc=%h required 16 3 4004",
                     level, drop_cnt, out_pc);
        end
    endtask

    task automatic test_full_pushpop();
        out_ready = 1'b1;
        reg_wr    = 1'b1;
        reg_waddr = 5'd9;
        step();
        idle();
        out_ready = 1'b0;
        tests++;
        if ({level, drop_cnt, out_pc} !== {5'd16, 16'd3, 32'h4008}) begin
            fails++;
            $display("FAIL full_pushpop: lvl=%0d drop=%0d pc=%h required 16 3 4008",
                     level, drop_cnt, out_pc);
        end
        out_ready = 1'b1;
        step();
        rst    = 1'b1;
        reg_wr = 1'b1;
        step();
        rst = 1'b0;
        idle();
        out_ready = 1'b0;
        tests++;
        if ({out_valid, level, overflow, drop_cnt} !== '0) begin
            fails++;
            $display("FAIL mid_reset: v=%b lvl=%0d ovf=%b drop=%0d required 0",
                     out_valid, level, overflow, drop_cnt);
        end
    endtask

    task automatic test_r0();
        out_ready = 1'b0;
        pc        = 32'h0000_5000;
        reg_wr    = 1'b1;
        reg_waddr = 5'd0;
        reg_wdata = 32'h5;
        step();
        idle();
        tests++;
`ifdef COMMIT_TRACE_DROP_R0_EN
        if ({level, drop_cnt} !== {5'd0, 16'd0}) begin
            fails++;
            $display("FAIL r0: lvl=%0d drop=%0d required 0 0", level, drop_cnt);
        end
`else
        if ({level, out_kind, out_addr, out_data} !== {5'd1, 2'b01, 32'h0, 32'h5}) begin
            fails++;
            $display("FAIL r0: lvl=%0d k=%b a=%h d=%h required 1 01 0 5",
                     level, out_kind, out_addr, out_data);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        mrec_t h;
        for (int i = 0; i < 600; i++) begin
            pc        = $urandom;
            reg_wr    = ($urandom_range(0, 2) != 0);
            reg_waddr = 5'($urandom_range(0, 31));
            reg_wdata = $urandom;
            mem_we    = ($urandom_range(0, 2) == 0);
            mem_addr  = 10'($urandom);
            mem_wdata = $urandom;
            out_ready = (i < 300) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
            step();
            h = (mq.size() > 0) ? mq[0] : '0;
            tests++;
            if ({out_valid, out_kind, out_pc, out_addr, out_data, level, overflow, drop_cnt} !==
                {mq.size() > 0, h.k, h.p, h.a, h.d, 5'(mq.size()), m_ovf, 16'(m_drop)}) begin
                fails++;
                $display("FAIL random[%0d]: v=%b k=%b pc=%h a=%h d=%h lvl=%0d ovf=%b drop=%0d required v=%b k=%b pc=%h a=%h d=%h lvl=%0d ovf=%b drop=%0d",
                         i, out_valid, out_kind, out_pc, out_addr, out_data, level, overflow, drop_cnt,
                         mq.size() > 0, h.k, h.p, h.a, h.d, mq.size(), m_ovf, m_drop);
            end
        end
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_gpr_only();
        test_dm_stall();
        test_dual();
        test_overflow();
        test_full_pushpop();
        test_r0();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
